// File: rtl/stage_d_decode.sv
// Decode stage of a five-stage MIPS-I pipeline.
// Registers the fetched instruction, decodes its fields, and reads operands
// through X/M forwarding and a 32x32 register file. It also requests a fetch
// restart for direct jumps (J/JAL) so fetch can redirect early.
module stage_d_decode (
  input  logic        clock,
  input  logic        rst,
  // From fetch
  input  logic        i_valid,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_npc,
  // X-stage result, used for forwarding
  input  logic        x_valid,
  input  logic [5:0]  x_wbr,
  input  logic [31:0] x_res,
  // M-stage writeback, used for forwarding and register file writes
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic [5:0]  m_wbr,
  input  logic [31:0] m_res,
  input  logic        flush_D,
  // Decoded instruction
  output logic        d_valid,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_npc,
  output logic [5:0]  d_opcode,
  output logic [5:0]  d_fn,
  output logic [4:0]  d_rd,
  output logic [4:0]  d_sa,
  output logic [5:0]  d_rs,
  output logic [5:0]  d_rt,
  output logic [31:0] d_target,
  output logic [5:0]  d_wbr,
  output logic        d_has_delay_slot,
  output logic [31:0] d_op1_val,
  output logic [31:0] d_op2_val,
  output logic [31:0] d_rt_val,
  output logic [31:0] d_simm,
  output logic        d_restart,
  output logic [31:0] d_restart_pc,
  output logic        d_flush_X
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic [31:0] r_regs [0:31];

  logic [5:0]  w_opcode;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs5;
  logic [4:0]  w_rt5;
  logic [15:0] w_imm;
  logic [31:0] w_simm;
  logic [31:0] w_target;
  logic [5:0]  w_wbr;
  logic        w_has_ds;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic        w_is_jump;
  logic        w_rf_we;
  logic        w_unused;

  // Operand read: X result beats M result beats the register file; r0 is 0.
  function automatic logic [31:0] read_operand(
    input logic [5:0]  r,
    input logic        xv,
    input logic [5:0]  xw,
    input logic [31:0] xr,
    input logic        mv,
    input logic [5:0]  mw,
    input logic [31:0] mr,
    input logic [31:0] rf
  );
    if (r == 6'd0)             return 32'd0;
    else if (xv && (xw == r))  return xr;
    else if (mv && (mw == r))  return mr;
    else                       return rf;
  endfunction

  // Pipeline register: capture the fetched instruction every cycle.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_npc   <= '0;
    end else begin
      r_valid <= i_valid;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_npc   <= i_npc;
    end
  end

  assign w_rf_we = m_valid && !m_wbr[5] && (m_wbr[4:0] != 5'd0);

  // Register file write port, fed by the M stage.
  // NOTE: the register file is cleared on reset because software relies on
  // registers reading 0 after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_rf_we) begin
      r_regs[m_wbr[4:0]] <= m_res;
    end
  end

  assign w_opcode  = r_instr[31:26];
  assign w_fn      = r_instr[5:0];
  assign w_rs5     = r_instr[25:21];
  assign w_rt5     = r_instr[20:16];
  assign w_imm     = r_instr[15:0];
  assign w_simm    = {{16{w_imm[15]}}, w_imm};
  assign w_is_jump = (w_opcode == OP_J) || (w_opcode == OP_JAL);
  assign w_target  = w_is_jump ? {r_npc[31:28], r_instr[25:0], 2'b00}
                               : r_npc + {w_simm[29:0], 2'b00};

  // Destination register selection by instruction class.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_wbr = 6'd0;
    case (w_opcode)
      OP_SPECIAL: if (w_fn != FN_JR) w_wbr = {1'b0, r_instr[15:11]};
      OP_REGIMM:  if (w_rt5 == 5'h10 || w_rt5 == 5'h11) w_wbr = 6'd31;
      OP_JAL:     w_wbr = 6'd31;
      6'h08, 6'h09, 6'h0A, 6'h0B, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                  w_wbr = {1'b0, w_rt5};
      OP_COP0:    if (w_rs5 == 5'd0) w_wbr = {1'b0, w_rt5};
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26:
                  w_wbr = {1'b0, w_rt5};
      default:    w_wbr = 6'd0;
    endcase
  end

  // Branches and jumps: all opcodes 1..7 plus register jumps JR/JALR.
  always_comb begin
    w_has_ds = 1'b0;
    if (w_opcode >= OP_REGIMM && w_opcode <= 6'h07)
      w_has_ds = 1'b1;
    else if (w_opcode == OP_SPECIAL && (w_fn == FN_JR || w_fn == FN_JALR))
      w_has_ds = 1'b1;
  end

  assign w_rs_val = read_operand({1'b0, w_rs5}, x_valid, x_wbr, x_res,
                                 m_valid, m_wbr, m_res, r_regs[w_rs5]);
  assign w_rt_val = read_operand({1'b0, w_rt5}, x_valid, x_wbr, x_res,
                                 m_valid, m_wbr, m_res, r_regs[w_rt5]);

  // ALU operand selection: shift amount, logical/upper immediates, or sign-extended.
  always_comb begin
    w_op1 = w_rs_val;
    if (w_opcode == OP_SPECIAL && (w_fn == FN_SLL || w_fn == FN_SRL || w_fn == FN_SRA))
      w_op1 = {27'd0, r_instr[10:6]};
    case (w_opcode)
      OP_SPECIAL:             w_op2 = w_rt_val;
      OP_ANDI, OP_ORI, OP_XORI: w_op2 = {16'd0, w_imm};
      OP_LUI:                 w_op2 = {w_imm, 16'd0};
      default:                w_op2 = w_simm;
    endcase
  end

  // The debug PC from M has no function here.
  assign w_unused = ^m_pc;

  assign d_valid          = r_valid;
  assign d_instr          = r_instr;
  assign d_pc             = r_pc;
  assign d_npc            = r_npc;
  assign d_opcode         = w_opcode;
  assign d_fn             = w_fn;
  assign d_rd             = r_instr[15:11];
  assign d_sa             = r_instr[10:6];
  assign d_rs             = {1'b0, w_rs5};
  assign d_rt             = {1'b0, w_rt5};
  assign d_target         = w_target;
  assign d_wbr            = w_wbr;
  assign d_has_delay_slot = w_has_ds;
  assign d_op1_val        = w_op1;
  assign d_op2_val        = w_op2;
  assign d_rt_val         = w_rt_val;
  assign d_simm           = w_simm;
  assign d_restart        = r_valid && !flush_D && w_is_jump;
  assign d_restart_pc     = w_target;
  assign d_flush_X        = 1'b0;

endmodule

// File: tb/tb_stage_d_decode.sv
// Scoreboard bench for stage_d_decode: expected outputs are queued when an
// instruction is driven and compared one clock later once it sits in D.
module tb_stage_d_decode;

  logic        clock = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_instr, i_pc, i_npc;
  logic        x_valid;
  logic [5:0]  x_wbr;
  logic [31:0] x_res;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [5:0]  m_wbr;
  logic [31:0] m_res;
  logic        flush_D;
  logic        d_valid;
  logic [31:0] d_instr, d_pc, d_npc;
  logic [5:0]  d_opcode, d_fn;
  logic [4:0]  d_rd, d_sa;
  logic [5:0]  d_rs, d_rt;
  logic [31:0] d_target;
  logic [5:0]  d_wbr;
  logic        d_has_delay_slot;
  logic [31:0] d_op1_val, d_op2_val, d_rt_val, d_simm;
  logic        d_restart;
  logic [31:0] d_restart_pc;
  logic        d_flush_X;

  int n_vec = 0;
  int n_err = 0;

  typedef enum {S_VALID, S_PC, S_WBR, S_OP1, S_OP2, S_RTV, S_SIMM, S_TGT,
                S_DS, S_RST, S_RPC, S_FLX} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  stage_d_decode dut (
    .clock(clock), .rst(rst),
    .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc), .i_npc(i_npc),
    .x_valid(x_valid), .x_wbr(x_wbr), .x_res(x_res),
    .m_valid(m_valid), .m_pc(m_pc), .m_wbr(m_wbr), .m_res(m_res),
    .flush_D(flush_D),
    .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc), .d_npc(d_npc),
    .d_opcode(d_opcode), .d_fn(d_fn), .d_rd(d_rd), .d_sa(d_sa),
    .d_rs(d_rs), .d_rt(d_rt), .d_target(d_target), .d_wbr(d_wbr),
    .d_has_delay_slot(d_has_delay_slot),
    .d_op1_val(d_op1_val), .d_op2_val(d_op2_val), .d_rt_val(d_rt_val),
    .d_simm(d_simm), .d_restart(d_restart), .d_restart_pc(d_restart_pc),
    .d_flush_X(d_flush_X)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] observe(sel_t s);
    case (s)
      S_VALID: return {31'd0, d_valid};
      S_PC:    return d_pc;
      S_WBR:   return {26'd0, d_wbr};
      S_OP1:   return d_op1_val;
      S_OP2:   return d_op2_val;
      S_RTV:   return d_rt_val;
      S_SIMM:  return d_simm;
      S_TGT:   return d_target;
      S_DS:    return {31'd0, d_has_delay_slot};
      S_RST:   return {31'd0, d_restart};
      S_RPC:   return d_restart_pc;
      default: return {31'd0, d_flush_X};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input sel_t s, input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag; e.sel = s; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    i_valid = 1'b1;
    i_instr = instr;
    i_pc    = pc;
    i_npc   = pc + 32'd4;
  endtask

  // Advance one clock, then retire everything the scoreboard expects of D.
  task automatic step();
    sb_t e;
    @(posedge clock);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  initial begin
    logic [5:0]  opc [5];
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic [31:0] xr, op2;

    opc = '{6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    rst = 1'b1; flush_D = 1'b0;
    x_valid = 1'b0; x_wbr = '0; x_res = '0;
    m_valid = 1'b0; m_wbr = '0; m_res = '0; m_pc = '0;
    drive(32'h2461_0000, 32'h0000_1000);   // ADDIU r1,r3,0 held during reset

    // Reset: D stays empty even though edges occur with valid input
    #12;
    check("rst_valid",   {31'd0, d_valid},   32'd0);
    check("rst_restart", {31'd0, d_restart}, 32'd0);
    check("rst_op1",     d_op1_val,          32'd0);
    check("rst_wbr",     {26'd0, d_wbr},     32'd0);
    rst = 1'b0;

    // ADDIU r2,r0,5
    drive(32'h2402_0005, 32'h0000_0100);
    expect_out(S_VALID, "addiu_valid", 32'd1);
    expect_out(S_PC,    "addiu_pc",    32'h0000_0100);
    expect_out(S_WBR,   "addiu_wbr",   32'd2);
    expect_out(S_OP1,   "addiu_op1",   32'd0);
    expect_out(S_OP2,   "addiu_op2",   32'd5);
    expect_out(S_SIMM,  "addiu_simm",  32'd5);
    expect_out(S_DS,    "addiu_ds",    32'd0);
    expect_out(S_FLX,   "flush_x",     32'd0);
    step();

    // Forwarding priority on rs=3: X over M, then M alone
    x_valid = 1'b1; x_wbr = 6'd3; x_res = 32'h0000_AAAA;
    m_valid = 1'b1; m_wbr = 6'd3; m_res = 32'h0000_BBBB;
    drive(32'h2461_0000, 32'h0000_0104);
    expect_out(S_OP1, "fwd_x", 32'h0000_AAAA);
    step();
    x_valid = 1'b0;
    expect_out(S_OP1, "fwd_m", 32'h0000_BBBB);
    step();

    // r0 is never written nor forwarded
    x_valid = 1'b1; x_wbr = 6'd0; x_res = 32'h1111_1111;
    m_valid = 1'b1; m_wbr = 6'd0; m_res = 32'hFFFF_FFFF;
    drive(32'h2401_0000, 32'h0000_0108);   // ADDIU r1,r0,0
    step();
    x_valid = 1'b0; m_valid = 1'b0;
    expect_out(S_OP1, "r0_zero", 32'd0);
    step();

    // J with instr_index 0x100000 from 0xBFC00000
    drive(32'h0810_0000, 32'hBFC0_0000);
    expect_out(S_TGT, "j_target",  32'hB040_0000);
    expect_out(S_RST, "j_restart", 32'd1);
    expect_out(S_RPC, "j_rpc",     32'hB040_0000);
    expect_out(S_DS,  "j_ds",      32'd1);
    expect_out(S_WBR, "j_wbr",     32'd0);
    step();
    flush_D = 1'b1;
    expect_out(S_RST, "j_flushed", 32'd0);
    step();
    flush_D = 1'b0;

    // LUI r4,0x1234
    drive(32'h3C04_1234, 32'h0000_0200);
    expect_out(S_OP2, "lui_op2", 32'h1234_0000);
    expect_out(S_WBR, "lui_wbr", 32'd4);
    step();

    // JAL: link to r31, pseudo-direct target within the npc region
    drive(32'h0C00_0010, 32'h0040_0000);
    expect_out(S_WBR, "jal_wbr", 32'd31);
    expect_out(S_TGT, "jal_tgt", 32'h0000_0040);
    expect_out(S_RST, "jal_rst", 32'd1);
    step();

    // BEQ r0,r0,-1: backwards branch target wraps to its own pc
    drive(32'h1000_FFFF, 32'h0000_0100);
    expect_out(S_TGT,  "beq_tgt",  32'h0000_0100);
    expect_out(S_SIMM, "beq_simm", 32'hFFFF_FFFF);
    expect_out(S_DS,   "beq_ds",   32'd1);
    expect_out(S_RST,  "beq_rst",  32'd0);
    expect_out(S_WBR,  "beq_wbr",  32'd0);
    step();

    // BGEZAL r0,+2: links r31
    drive(32'h0411_0002, 32'h0000_1000);
    expect_out(S_WBR, "bgezal_wbr", 32'd31);
    expect_out(S_TGT, "bgezal_tgt", 32'h0000_100C);
    step();

    // JR r31: no writeback, has delay slot
    drive(32'h03E0_0008, 32'h0000_2000);
    expect_out(S_WBR, "jr_wbr", 32'd0);
    expect_out(S_DS,  "jr_ds",  32'd1);
    step();

    // SLL r1,r2,7: op1 is the shift amount
    drive(32'h0002_09C0, 32'h0000_2004);
    expect_out(S_OP1, "sll_op1", 32'd7);
    expect_out(S_WBR, "sll_wbr", 32'd1);
    step();

    // Register file write of r5 through M, then a blocked write (wbr bit 5 set)
    m_valid = 1'b1; m_wbr = 6'd5; m_res = 32'h1234_5678;
    drive(32'h00A6_3821, 32'h0000_3000);   // ADDU r7,r5,r6
    expect_out(S_OP1, "addu_op1_fwd", 32'h1234_5678);
    expect_out(S_OP2, "addu_op2",     32'd0);
    expect_out(S_WBR, "addu_wbr",     32'd7);
    step();
    m_wbr = 6'h25; m_res = 32'hDEAD_BEEF;
    expect_out(S_OP1, "rf_r5", 32'h1234_5678);
    step();
    m_valid = 1'b0;
    expect_out(S_OP1, "rf_r5_nowr", 32'h1234_5678);
    expect_out(S_RTV, "rf_r6",      32'd0);
    step();

    // Random immediate-class instructions with rs forwarded from X
    for (int i = 0; i < 8; i++) begin
      op  = opc[$urandom_range(0, 4)];
      rs  = 5'($urandom_range(1, 31));
      rt  = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      xr  = $urandom;
      x_valid = 1'b1; x_wbr = {1'b0, rs}; x_res = xr;
      drive({op, rs, rt, imm}, 32'h0001_0000 + 32'(i * 4));
      case (op)
        6'h0C, 6'h0D, 6'h0E: op2 = {16'd0, imm};
        6'h0F:               op2 = {imm, 16'd0};
        default:             op2 = {{16{imm[15]}}, imm};
      endcase
      expect_out(S_OP1,  "rnd_op1",  xr);
      expect_out(S_OP2,  "rnd_op2",  op2);
      expect_out(S_WBR,  "rnd_wbr",  {27'd0, rt});
      expect_out(S_SIMM, "rnd_simm", {{16{imm[15]}}, imm});
      step();
    end
    x_valid = 1'b0;

    // Invalid fetch propagates as an empty D
    i_valid = 1'b0;
    expect_out(S_VALID, "bubble_valid", 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
